ll_multi_queue: RTL and testbench

Parametrised linked-list multi-queue buffer. NUM_Q logical FIFOs share one pool of DEPTH data entries. Per-queue head/tail pointers and a shared next-pointer array chain the entries; a circular free-index list recycles popped entries. It sits between ingress classification and per-queue schedulers, replacing fixed per-channel FIFOs with a shared pool of runtime-allocated entries.

---
 rtl/ll_multi_queue_if.sv | 32 +++
 rtl/ll_multi_queue.sv | 102 ++++++++++
 tb/tb_ll_multi_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ll_multi_queue_if.sv
// rtl/ll_multi_queue_if.sv - push/pop/status bundle for the linked-list multi-queue
interface ll_multi_queue_if #(
  parameter int NUM_Q  = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int QID_W = $clog2(NUM_Q);
  localparam int PTR_W = $clog2(DEPTH);

  logic              push_en;
  logic [QID_W-1:0]  push_qid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              push_err;
  logic              pop_en;
  logic [QID_W-1:0]  pop_qid;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_err;
  logic [NUM_Q-1:0]  q_empty;
  logic [PTR_W:0]    free_count;

  modport master (
    output push_en, push_qid, push_data, pop_en, pop_qid,
    input  push_ready, push_err, pop_valid, pop_data, pop_err, q_empty, free_count
  );

  modport slave (
    input  push_en, push_qid, push_data, pop_en, pop_qid,
    output push_ready, push_err, pop_valid, pop_data, pop_err, q_empty, free_count
  );
endinterface

// File: rtl/ll_multi_queue.sv
// rtl/ll_multi_queue.sv - NUM_Q linked-list FIFOs sharing one DEPTH-entry pool
module ll_multi_queue #(
  parameter int NUM_Q  = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           reset,
  ll_multi_queue_if.slave bus
);
  localparam int QID_W = $clog2(NUM_Q);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [PTR_W-1:0]  next_ptr  [DEPTH];
  logic [PTR_W-1:0]  free_fifo [DEPTH];
  logic [PTR_W-1:0]  head      [NUM_Q];
  logic [PTR_W-1:0]  tail      [NUM_Q];
  logic [PTR_W:0]    free_rd;
  logic [PTR_W:0]    free_wr;
  logic [PTR_W:0]    free_count;
  logic [NUM_Q-1:0]  q_empty;
  logic              pop_valid;
  logic              pop_err;
  logic              push_err;
  logic [DATA_W-1:0] pop_data;

  logic              push_ready;
  logic              push_ok;
  logic              pop_ok;
  logic [PTR_W-1:0]  alloc;
  logic [PTR_W-1:0]  pop_head;
  logic              pop_last;
  logic              restart_q;

  assign push_ready = (free_count != '0);
  assign push_ok    = bus.push_en && push_ready;
  assign pop_ok     = bus.pop_en && !q_empty[bus.pop_qid];
  assign alloc      = free_fifo[free_rd[PTR_W-1:0]];
  assign pop_head   = head[bus.pop_qid];
  assign pop_last   = (pop_head == tail[bus.pop_qid]);
  // A push that lands on a queue being drained of its last entry restarts it.
  assign restart_q  = q_empty[bus.push_qid] ||
                      (pop_ok && pop_last && (bus.pop_qid == bus.push_qid));

  always_ff @(posedge clk) begin
    if (push_ok) data_mem[alloc] <= bus.push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        free_fifo[i] <= PTR_W'(i);
        next_ptr[i]  <= '0;
      end
      for (int q = 0; q < NUM_Q; q++) begin
        head[q] <= '0;
        tail[q] <= '0;
      end
      free_rd    <= '0;
      free_wr    <= FULL;
      free_count <= FULL;
      q_empty    <= '1;
      pop_valid  <= 1'b0;
      pop_err    <= 1'b0;
      push_err   <= 1'b0;
      pop_data   <= '0;
    end else begin
      push_err   <= bus.push_en && !push_ready;
      pop_err    <= bus.pop_en && q_empty[bus.pop_qid];
      pop_valid  <= pop_ok;
      free_count <= free_count + (pop_ok ? ONE : '0) - (push_ok ? ONE : '0);

      if (pop_ok) begin
        pop_data                       <= data_mem[pop_head];
        free_fifo[free_wr[PTR_W-1:0]]  <= pop_head;
        free_wr                        <= free_wr + ONE;
        if (pop_last) q_empty[bus.pop_qid] <= 1'b1;
        else          head[bus.pop_qid]    <= next_ptr[pop_head];
      end

      // Push updates follow the pop so they win on a shared queue.
      if (push_ok) begin
        free_rd <= free_rd + ONE;
        if (restart_q) head[bus.push_qid] <= alloc;
        else           next_ptr[tail[bus.push_qid]] <= alloc;
        tail[bus.push_qid]    <= alloc;
        q_empty[bus.push_qid] <= 1'b0;
      end
    end
  end

  assign bus.push_ready = push_ready;
  assign bus.push_err   = push_err;
  assign bus.pop_valid  = pop_valid;
  assign bus.pop_data   = pop_data;
  assign bus.pop_err    = pop_err;
  assign bus.q_empty    = q_empty;
  assign bus.free_count = free_count;
endmodule

// File: tb/tb_ll_multi_queue.sv
// tb/tb_ll_multi_queue.sv - scoreboard bench for ll_multi_queue
module tb_ll_multi_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ll_multi_queue_if #(.NUM_Q(4), .DEPTH(16), .DATA_W(8)) bus ();
  ll_multi_queue #(.NUM_Q(4), .DEPTH(16), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mq0[$], mq1[$], mq2[$], mq3[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int q);
    case (q)
      0: return mq0.size();
      1: return mq1.size();
      2: return mq2.size();
      default: return mq3.size();
    endcase
  endfunction

  function automatic int used();
    return mq0.size() + mq1.size() + mq2.size() + mq3.size();
  endfunction

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int q = 0; q < 4; q++) e[q] = (qsize(q) == 0);
    return e;
  endfunction

  task automatic model_pop(input int q, output logic [7:0] d);
    case (q)
      0: d = mq0.pop_front();
      1: d = mq1.pop_front();
      2: d = mq2.pop_front();
      default: d = mq3.pop_front();
    endcase
  endtask

  task automatic model_push(input int q, input logic [7:0] d);
    case (q)
      0: mq0.push_back(d);
      1: mq1.push_back(d);
      2: mq2.push_back(d);
      default: mq3.push_back(d);
    endcase
  endtask

  task automatic check_status();
    check("free_count", 32'(bus.free_count), 32'(16 - used()));
    check("q_empty",    32'(bus.q_empty),    32'(exp_empty()));
    check("push_ready", 32'(bus.push_ready), 32'(used() != 16));
  endtask

  task automatic cycle(input logic pe, input int pq, input logic [7:0] pd,
                       input logic oe, input int oq);
    logic       e_perr, e_oerr, e_valid;
    logic [7:0] d;
    @(negedge clk);
    bus.push_en   = pe;
    bus.push_qid  = 2'(pq);
    bus.push_data = pd;
    bus.pop_en    = oe;
    bus.pop_qid   = 2'(oq);
    e_perr  = pe && (used() == 16);
    e_oerr  = oe && (qsize(oq) == 0);
    e_valid = oe && !e_oerr;
    if (e_valid) begin
      model_pop(oq, d);
      exp_q.push_back(d);
    end
    if (pe && !e_perr) model_push(pq, pd);
    @(posedge clk);
    #1;
    check("pop_valid", 32'(bus.pop_valid), 32'(e_valid));
    if (bus.pop_valid) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'(bus.pop_data), 32'hdead);
      else                   check("pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
    end
    check("push_err", 32'(bus.push_err), 32'(e_perr));
    check("pop_err",  32'(bus.pop_err),  32'(e_oerr));
    check_status();
  endtask

  task automatic do_reset(input logic pop_req);
    @(negedge clk);
    reset       = 1'b1;
    bus.push_en = pop_req;
    bus.pop_en  = pop_req;
    bus.pop_qid = 2'd0;
    mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    check("rst_pop_err",   32'(bus.pop_err),   32'd0);
    check("rst_push_err",  32'(bus.push_err),  32'd0);
    check_status();
    @(negedge clk);
    reset       = 1'b0;
    bus.push_en = 1'b0;
    bus.pop_en  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.push_en = 1'b0; bus.push_qid = '0; bus.push_data = '0;
    bus.pop_en  = 1'b0; bus.pop_qid  = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    check("reset_q_empty",    32'(bus.q_empty),    32'hf);
    check("reset_free_count", 32'(bus.free_count), 32'd16);

    // Order within one queue, back-to-back pops.
    cycle(1, 2, 8'hA1, 0, 0);
    cycle(1, 2, 8'hA2, 0, 0);
    cycle(1, 2, 8'hA3, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 2);

    // Interleave two queues.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 8'(8'h10 + i), 0, 0);
      cycle(1, 3, 8'(8'h30 + i), 0, 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

    // Full pool, then push+pop together.
    for (int i = 0; i < 16; i++) cycle(1, 1, 8'(8'h80 + i), 0, 0);
    cycle(1, 1, 8'hEE, 1, 1);
    cycle(1, 2, 8'hEF, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, (i < 15) ? 1 : 2);

    // Empty and single-entry corner cases.
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 8'h55, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 8'h55, 0, 0);
    cycle(1, 0, 8'h66, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 2, 8'h70, 0, 0);
    cycle(1, 2, 8'h71, 0, 0);
    cycle(1, 2, 8'h72, 1, 2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 2);

    // Recycling of freed entries after a fresh reset.
    do_reset(1'b0);
    cycle(1, 1, 8'h01, 0, 0);
    cycle(1, 1, 8'h02, 0, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 1, 8'h03, 0, 0);
    for (int i = 0; i < 15; i++) cycle(1, 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 1, 1);

    // Reset in the middle of traffic, with a pop request in the reset cycle.
    cycle(1, 3, 8'h99, 0, 0);
    cycle(1, 3, 8'h9A, 0, 0);
    do_reset(1'b1);
    cycle(0, 0, 0, 1, 3);

    // Random mixed traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    cycle(0, 0, 0, 0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
